// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, state codes
// and the bit layout of the opcode-class vector.
package cpu_ctrl_pkg;

   localparam logic [4:0] OPC_BR   = 5'b10010;
   localparam logic [4:0] OPC_JR   = 5'b10011;
   localparam logic [4:0] OPC_JAL  = 5'b10100;
   localparam logic [4:0] OPC_NOP  = 5'b11010;
   localparam logic [4:0] OPC_HALT = 5'b11011;

   localparam logic [3:0] ST_T0   = 4'd0;
   localparam logic [3:0] ST_T1   = 4'd1;
   localparam logic [3:0] ST_T2   = 4'd2;
   localparam logic [3:0] ST_T3   = 4'd3;
   localparam logic [3:0] ST_T4   = 4'd4;
   localparam logic [3:0] ST_T5   = 4'd5;
   localparam logic [3:0] ST_T6   = 4'd6;
   localparam logic [3:0] ST_HALT = 4'd15;

   // Bit positions inside the one-hot opcode-class vector.
   localparam int CLS_BR      = 5;
   localparam int CLS_JR      = 4;
   localparam int CLS_JAL     = 3;
   localparam int CLS_NOP     = 2;
   localparam int CLS_HALT    = 1;
   localparam int CLS_ILLEGAL = 0;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: IR[31:27] to a one-hot
// {is_br, is_jr, is_jal, is_nop, is_halt, is_illegal} vector.
module opcode_decode
   import cpu_ctrl_pkg::*;
#(
   parameter logic [4:0] OP_BR   = OPC_BR,
   parameter logic [4:0] OP_JR   = OPC_JR,
   parameter logic [4:0] OP_JAL  = OPC_JAL,
   parameter logic [4:0] OP_NOP  = OPC_NOP,
   parameter logic [4:0] OP_HALT = OPC_HALT
) (
   input  logic [4:0] opcode_i,
   output logic [5:0] op_cls_o
);

   always_comb begin
      op_cls_o = 6'b000000;
      if (opcode_i == OP_BR)        op_cls_o[CLS_BR]      = 1'b1;
      else if (opcode_i == OP_JR)   op_cls_o[CLS_JR]      = 1'b1;
      else if (opcode_i == OP_JAL)  op_cls_o[CLS_JAL]     = 1'b1;
      else if (opcode_i == OP_NOP)  op_cls_o[CLS_NOP]     = 1'b1;
      else if (opcode_i == OP_HALT) op_cls_o[CLS_HALT]    = 1'b1;
      else                          op_cls_o[CLS_ILLEGAL] = 1'b1;
   end

endmodule

// File: rtl/ctrl_seq.sv
// Hardwired control sequencer: fetch T0..T2, opcode-dependent execute T3..T6,
// absorbing HALT. Strobes are decoded from the present state and the opcode.
module ctrl_seq
   import cpu_ctrl_pkg::*;
#(
   parameter logic [4:0] OP_BR   = OPC_BR,
   parameter logic [4:0] OP_JR   = OPC_JR,
   parameter logic [4:0] OP_JAL  = OPC_JAL,
   parameter logic [4:0] OP_NOP  = OPC_NOP,
   parameter logic [4:0] OP_HALT = OPC_HALT
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR,
   input  logic        CON,
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Gra,
   output logic        Grb,
   output logic        Rout,
   output logic        Rin,
   output logic        R15in,
   output logic        CONin,
   output logic        Yin,
   output logic        Cout,
   output logic        BRANCH,
   output logic        Zin,
   output logic        Zlowout,
   output logic        PCin,
   output logic        Run,
   output logic        Illegal,
   output logic [3:0]  state
);

   logic [3:0] state_q, state_d;
   logic [5:0] op_cls;
   logic       unused_ir_fields;

   assign unused_ir_fields = ^IR[26:0];

   opcode_decode #(
      .OP_BR  (OP_BR),
      .OP_JR  (OP_JR),
      .OP_JAL (OP_JAL),
      .OP_NOP (OP_NOP),
      .OP_HALT(OP_HALT)
   ) u_opcode_decode (
      .opcode_i(IR[31:27]),
      .op_cls_o(op_cls)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= ST_T0;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = ST_T0;
      case (state_q)
         ST_T0: state_d = ST_T1;
         ST_T1: state_d = ST_T2;
         ST_T2: state_d = ST_T3;
         ST_T3: begin
            if (op_cls[CLS_BR] || op_cls[CLS_JAL]) state_d = ST_T4;
            else if (op_cls[CLS_HALT])             state_d = ST_HALT;
            else                                   state_d = ST_T0;
         end
         ST_T4:   state_d = op_cls[CLS_BR] ? ST_T5 : ST_T0;
         ST_T5:   state_d = ST_T6;
         ST_T6:   state_d = ST_T0;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_T0;
      endcase
   end

   // Strobes are masked by clr so they drop the moment reset is asserted,
   // even though the reset state T0 would otherwise drive the fetch strobes.
   always_comb begin
      PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Read = 1'b0; MDRin = 1'b0;
      MDRout = 1'b0; IRin = 1'b0; Gra = 1'b0; Grb = 1'b0; Rout = 1'b0;
      Rin = 1'b0; R15in = 1'b0; CONin = 1'b0; Yin = 1'b0; Cout = 1'b0;
      BRANCH = 1'b0; Zin = 1'b0; Zlowout = 1'b0; PCin = 1'b0; Illegal = 1'b0;
      if (!clr) begin
         case (state_q)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            ST_T1: begin Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
               if (op_cls[CLS_BR]) begin
                  Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
               end else if (op_cls[CLS_JR]) begin
                  Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
               end else if (op_cls[CLS_JAL]) begin
                  PCout = 1'b1; R15in = 1'b1;
               end else if (op_cls[CLS_ILLEGAL]) begin
                  Illegal = 1'b1;
               end
            end
            ST_T4: begin
               if (op_cls[CLS_BR]) begin
                  PCout = 1'b1; Yin = 1'b1;
               end else if (op_cls[CLS_JAL]) begin
                  Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
               end
            end
            ST_T5: begin Cout = 1'b1; BRANCH = 1'b1; Zin = 1'b1; end
            ST_T6: begin Zlowout = 1'b1; PCin = CON; end
            default: ;
         endcase
      end
   end

   assign Run   = (state_q != ST_HALT);
   assign state = state_q;

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Hardwired control sequencer that drives the datapath's control-signal interface from the fetched instruction. It generates, cycle by cycle, the same control strobes a bench would otherwise hand-drive: instruction fetch, the conditional-branch sequence, `jr`, `jal`, `nop` and `halt`. It sits beside `Datapath` and consumes `IRdataout` and `CON`, replacing hand-sequenced stimulus.

## Interface
- `OP_BR`, default 5'b10010: conditional branch opcode (brzr/brnz/brpl/brmi; condition code in IR[22:19] is evaluated by the datapath CON logic).
- `OP_JR`, default 5'b10011: jump register.
- `OP_JAL`, default 5'b10100: jump and link, R15 <- PC, PC <- Ra.
- `OP_NOP`, default 5'b11010: no operation.
- `OP_HALT`, default 5'b11011: halt.
- `clk` in 1: clock, rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `IR` in 32: `IRdataout`; opcode is IR[31:27].
- `CON` in 1: branch-condition flip-flop output from the datapath.
- `PCout, MARin, IncPC, Read, MDRin, MDRout, IRin` out 1 each: fetch strobes.
- `Gra, Grb, Rout, Rin, R15in, CONin, Yin, Cout, BRANCH, Zin, Zlowout, PCin` out 1 each: execute strobes.
- `Run` out 1: 1 while sequencing, 0 in HALT.
- `Illegal` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: present-state code, for monitoring.

## Operation
- States: T0..T6 (4'd0..4'd6) and HALT (4'd15). All strobes are decoded from the present state and the IR opcode. Any strobe not listed for a state is 0.
- T0: PCout, MARin, IncPC. Next state is T1.
- T1: Read, MDRin. Next state is T2.
- T2: MDRout, IRin. IR is valid from the following edge. Next state is T3.
- T3 decode:
  - br: Gra, Rout, CONin. Next state is T4.
  - jr: Gra, Rout, PCin. Next state is T0.
  - jal: PCout, R15in. Next state is T4.
  - nop: no strobes. Next state is T0.
  - halt: no strobes. Next state is HALT.
  - Any other opcode: Illegal=1, no strobes. Next state is T0.
- T4:
  - br: PCout, Yin. Next state is T5.
  - jal: Gra, Rout, PCin. Next state is T0.
- T5 (br only): Cout, BRANCH, Zin. Next state is T6.
- T6 (br only): Zlowout, plus PCin only if CON=1. Next state is T0.
- HALT: Run=0, all strobes 0. The block stays in HALT until `clr`.
- CON is sampled combinationally during T6 only. CON is latched by the datapath at the end of T3.

## Timing
- One state per clock. Instruction lengths, including fetch: br 7 cycles, jr 4, jal 5, nop 4, illegal 4.
- Reset value: state=T0, Run=1, Illegal=0. Every other output is 0 while `clr` is high.
- Asserting `clr` in any state, including mid-branch or HALT, forces T0 asynchronously. All strobes drop immediately. The first fetch (PCout/MARin/IncPC) begins in the first cycle after `clr` deasserts.
- A strobe is valid from shortly after one rising edge until the next. The datapath samples on the edge that ends the state.
- Read in T1 assumes RAM data is available to MDR by the end of T1.
- HALT is absorbing. A new opcode on IR while in HALT has no effect.
- Sequencing depends on opcode only. Ra/Rb fields pass to the datapath via Gra/Grb.

## Structure
- Shared package `cpu_ctrl_pkg` holds the opcode constants (matching the parameter defaults) and the state encoding (T0..T6, HALT).
- One sub-module, `opcode_decode`: combinational IR[31:27] to one-hot {is_br, is_jr, is_jal, is_nop, is_halt, is_illegal}.
- The top level contains the state register and the output decode.

## Test plan
- Reset then brmi R6,25 with IR=0x93180019 and CON=1:
  - States go T0..T6 then T0.
  - T3 has Gra, Rout, CONin. T5 has Cout, BRANCH, Zin. T6 has Zlowout and PCin.
  - With PC=12 and R6=0xFFFFDEBD, PC becomes 13+25=38.
- Same branch with CON=0: T6 asserts Zlowout with PCin=0, and PC stays 13.
- jr with IR=0x99800000 (Ra=R3, R3=0x40): T3 has Gra, Rout, PCin. Next state is T0 and PC becomes 0x40. Total 4 cycles.
- jal with IR=0xA2000000 (Ra=R4): T3 has PCout and R15in, so R15 becomes the incremented PC. T4 has Gra, Rout, PCin. Total 5 cycles.
- Opcode 5'b11111 gives an Illegal pulse in T3 and the next state is T0. Halt (0xD8000000) gives Run=0 and state=HALT held for 20 cycles with all strobes 0.
- `clr` pulsed asynchronously mid-T5 of a branch: all strobes go 0 immediately and state=T0. After release, fetch restarts and Zin is never asserted for the aborted branch.
